regfile: RTL and testbench

Integer register file for the ID stage: 31 general-purpose 32-bit registers plus hardwired-zero x0, two read channels and one write channel. It sits directly upstream of the operand bypass logic. It serves only the reads the bypass logic actually issues, which are those not satisfied by EX/MEM/WB forwarding. It accepts the WB-stage destination write. Each read channel holds its last returned value while idle, so downstream operand muxes see stable data.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_if.sv | 29 ++
 rtl/regfile_rd_port.sv | 49 ++++
 rtl/regfile.sv | 63 ++++++
 tb/tb_regfile.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared core constants for the integer register file, operand bypass and decoder.
package regfile_pkg;

  localparam int XLEN    = 32;
  localparam int REG_AW  = 5;
  localparam int REG_NUM = 2 ** REG_AW;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef logic [XLEN-1:0]   xword_t;
  typedef logic [REG_AW-1:0] raddr_t;

endpackage

// File: rtl/regfile_if.sv
// Register-file bus: two read channels and the write-back destination write.
interface regfile_if;
  import regfile_pkg::*;

  logic              register_rd_ch0_en;
  logic [REG_AW-1:0] register_rd_ch0_addr;
  logic [XLEN-1:0]   register_rd_ch0_data;
  logic              register_rd_ch1_en;
  logic [REG_AW-1:0] register_rd_ch1_addr;
  logic [XLEN-1:0]   register_rd_ch1_data;
  logic              wb_dest_we_valid;
  logic [REG_AW-1:0] wb_dest_we_addr;
  logic [XLEN-1:0]   wb_dest_we_data;

  modport master (
    output register_rd_ch0_en, register_rd_ch0_addr,
    output register_rd_ch1_en, register_rd_ch1_addr,
    output wb_dest_we_valid, wb_dest_we_addr, wb_dest_we_data,
    input  register_rd_ch0_data, register_rd_ch1_data
  );

  modport slave (
    input  register_rd_ch0_en, register_rd_ch0_addr,
    input  register_rd_ch1_en, register_rd_ch1_addr,
    input  wb_dest_we_valid, wb_dest_we_addr, wb_dest_we_data,
    output register_rd_ch0_data, register_rd_ch1_data
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One read channel: 32:1 row mux, x0 zero-forcing, and a hold register that
// keeps the last returned value on the output while the channel is idle.
module regfile_rd_port
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic [REG_AW-1:0]       addr_i,
  input  logic [REG_NUM*XLEN-1:0] regs_i,
  output logic [XLEN-1:0]         data_o
);

  logic [XLEN-1:0] sel_s;
  logic [XLEN-1:0] rd_val_s;
  logic [XLEN-1:0] hold_d;
  logic [XLEN-1:0] hold_q;

  // Row select; x0 is forced to zero regardless of what the array slot holds
  always_comb begin
    sel_s = regs_i[addr_i*XLEN +: XLEN];
    if (addr_i == REG_ZERO) begin
      rd_val_s = {XLEN{1'b0}};
    end else begin
      rd_val_s = sel_s;
    end
  end

  // Enable selects live data and refreshes the hold value; idle replays the hold value
  always_comb begin
    if (en_i) begin
      data_o = rd_val_s;
      hold_d = rd_val_s;
    end else begin
      data_o = hold_q;
      hold_d = hold_q;
    end
  end

  // Hold register state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= {XLEN{1'b0}};
    end else begin
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/regfile.sv
// ID-stage integer register file: x1..x31 in flops, hardwired-zero x0, two read
// channels and one write-back port. Reads are combinational and never see the same-cycle write.
module regfile
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave bus
);

  logic [REG_NUM-1:1]      we_dec_s;
  logic [REG_NUM*XLEN-1:0] regs_flat_s;

  // Flat one-hot write strobe; no strobe exists for x0, so its writes vanish
  always_comb begin
    we_dec_s = {(REG_NUM-1){1'b0}};
    for (int i = 1; i < REG_NUM; i++) begin
      if (bus.wb_dest_we_valid && (bus.wb_dest_we_addr == REG_AW'(i))) begin
        we_dec_s[i] = 1'b1;
      end else begin
        we_dec_s[i] = 1'b0;
      end
    end
  end

  assign regs_flat_s[XLEN-1:0] = {XLEN{1'b0}};

  for (genvar g = 1; g < REG_NUM; g++) begin : g_reg
    logic [XLEN-1:0] reg_q;

    // Architectural register storage
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        reg_q <= {XLEN{1'b0}};
      end else if (we_dec_s[g]) begin
        reg_q <= bus.wb_dest_we_data;
      end else begin
        reg_q <= reg_q;
      end
    end

    assign regs_flat_s[g*XLEN +: XLEN] = reg_q;
  end

  regfile_rd_port u_rd_ch0 (
    .clk    (clk),
    .reset  (reset),
    .en_i   (bus.register_rd_ch0_en),
    .addr_i (bus.register_rd_ch0_addr),
    .regs_i (regs_flat_s),
    .data_o (bus.register_rd_ch0_data)
  );

  regfile_rd_port u_rd_ch1 (
    .clk    (clk),
    .reset  (reset),
    .en_i   (bus.register_rd_ch1_en),
    .addr_i (bus.register_rd_ch1_addr),
    .regs_i (regs_flat_s),
    .data_o (bus.register_rd_ch1_data)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus random traffic
// compared against an array-based model of the register file.
module tb_regfile;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_if bus ();

  regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  logic [31:0] hold0;
  logic [31:0] hold1;
  logic [31:0] obs0;
  logic [31:0] obs1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic en, input logic [4:0] a,
                                             input logic [31:0] hold);
    if (!en) return hold;
    if (a == 5'd0) return 32'd0;
    return mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    hold0 = 32'd0;
    hold1 = 32'd0;
  endtask

  task automatic drive(input logic en0, input logic [4:0] a0, input logic en1,
                       input logic [4:0] a1, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    bus.register_rd_ch0_en   = en0;
    bus.register_rd_ch0_addr = a0;
    bus.register_rd_ch1_en   = en1;
    bus.register_rd_ch1_addr = a1;
    bus.wb_dest_we_valid     = we;
    bus.wb_dest_we_addr      = wa;
    bus.wb_dest_we_data      = wd;
  endtask

  // One clock cycle: drive just after the edge, check mid-cycle, update the model at the edge.
  task automatic cycle(input logic en0, input logic [4:0] a0, input logic en1,
                       input logic [4:0] a1, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    logic [31:0] e0;
    logic [31:0] e1;
    drive(en0, a0, en1, a1, we, wa, wd);
    #2;
    e0   = model_read(en0, a0, hold0);
    e1   = model_read(en1, a1, hold1);
    obs0 = bus.register_rd_ch0_data;
    obs1 = bus.register_rd_ch1_data;
    check_val("model_ch0", obs0, e0);
    check_val("model_ch1", obs1, e1);
    @(posedge clk);
    if (en0) hold0 = e0;
    if (en1) hold1 = e1;
    if (we && (wa != 5'd0)) mem[wa] = wd;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    drive(1'b0, 5'd17, 1'b0, 5'd3, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #1;
    check_val("rst_idle_ch0", bus.register_rd_ch0_data, 32'd0);
    check_val("rst_idle_ch1", bus.register_rd_ch1_data, 32'd0);
    drive(1'b1, 5'd31, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
    #1;
    check_val("rst_en_ch0", bus.register_rd_ch0_data, 32'd0);
    check_val("rst_en_ch1", bus.register_rd_ch1_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fresh-state reads
    cycle(1'b1, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
    check_val("init_a0", obs0, 32'd0);
    check_val("init_a5", obs1, 32'd0);
    cycle(1'b1, 5'd31, 1'b1, 5'd31, 1'b0, 5'd0, 32'd0);
    check_val("init_a31", obs0, 32'd0);

    // Write latency and read-old-on-collision
    cycle(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    check_val("same_cycle_old", obs0, 32'd0);
    cycle(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 32'd0);
    check_val("wr_visible", obs0, 32'hDEAD_BEEF);
    check_val("dual_same_addr", obs1, 32'hDEAD_BEEF);

    // x0 is immutable
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cycle(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 32'd0);
    check_val("x0_ch0", obs0, 32'd0);
    check_val("x0_ch1", obs1, 32'd0);

    // Hold behaviour on ch1
    cycle(1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 5'd7, 32'h1234_5678);
    check_val("hold_src", obs1, 32'hDEAD_BEEF);
    cycle(1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 5'd0, 32'd0);
    check_val("hold_keep", obs1, 32'hDEAD_BEEF);
    cycle(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
    check_val("hold_release", obs1, 32'h1234_5678);

    // Fill and opposite-order sweep
    for (int i = 1; i < 32; i++) begin
      cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(i), 32'h1000_0000 + 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 5'(i), 1'b1, 5'(31 - i), 1'b0, 5'd0, 32'd0);
      check_val("sweep_ch0", obs0, (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i));
      check_val("sweep_ch1", obs1, (i == 31) ? 32'd0 : 32'h1000_0000 + 32'(31 - i));
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
    end

    // Asynchronous reset mid-cycle
    cycle(1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd9, 32'hA5A5_A5A5);
    cycle(1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0);
    check_val("pre_rst_ch0", obs0, 32'hA5A5_A5A5);
    check_val("pre_rst_ch1", obs1, 32'hA5A5_A5A5);
    drive(1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 5'd3, 32'h3333_3333);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_hold_ch0", bus.register_rd_ch0_data, 32'd0);
    check_val("async_hold_ch1", bus.register_rd_ch1_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 5'd9, 1'b0, 5'd3, 1'b0, 5'd0, 32'd0);
    check_val("post_rst_hold0", obs0, 32'd0);
    check_val("post_rst_hold1", obs1, 32'd0);
    cycle(1'b1, 5'd9, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0);
    check_val("post_rst_x9", obs0, 32'd0);
    check_val("post_rst_lost_wr", obs1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
